// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the CPU run controller: FSM states and button/event indices.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_RESET = 2'd3
  } state_t;

  // Lower index wins when press events coincide.
  localparam int EV_CPURST = 0;
  localparam int EV_RUN    = 1;
  localparam int EV_STEP   = 2;
  localparam int NUM_EV    = 3;

endpackage

// File: rtl/cpu_run_ctrl_btn_filter.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and press pulse.
module btn_filter #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
      press  <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // press rises together with the filtered level; releases never pulse
        level <= ~level;
        press <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Board run controller for the MIPS core: button events drive a HALT/RUN/STEP/RESET FSM.
// Optional breakpoint halting is compiled in when BREAKPOINT_EN is defined.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DB_CYCLES  = 1_000_000,
  parameter int CNT_W      = 20,
  parameter int RST_CYCLES = 4,
  parameter int PC_W       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_run,
  input  logic            btn_step,
  input  logic            btn_cpurst,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] bp_addr,
  input  logic            bp_valid,
  output logic            cpu_en,
  output logic            cpu_rst,
  output logic [1:0]      state_o,
  output logic [15:0]     step_cnt
);

  localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RST_CYCLES - 1);

  state_t            state;
  state_t            state_next;
  logic [RCNT_W-1:0] rcnt;
  logic [NUM_EV-1:0] btn_raw;
  logic [NUM_EV-1:0] press;
  logic [NUM_EV-1:0] level;
  logic [NUM_EV-1:0] ev;
  logic              bp_hit;

  always_comb begin
    btn_raw            = '0;
    btn_raw[EV_CPURST] = btn_cpurst;
    btn_raw[EV_RUN]    = btn_run;
    btn_raw[EV_STEP]   = btn_step;
  end

  for (genvar i = 0; i < NUM_EV; i++) begin : g_filt
    btn_filter #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_filt (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_raw[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  logic unused_level;
  assign unused_level = ^level;

  // Coincident presses: only the highest-priority one survives.
  always_comb begin
    ev            = '0;
    ev[EV_CPURST] = press[EV_CPURST];
    ev[EV_RUN]    = press[EV_RUN] & ~press[EV_CPURST];
    ev[EV_STEP]   = press[EV_STEP] & ~press[EV_RUN] & ~press[EV_CPURST];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RESET;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_HALT: begin
        if (ev[EV_CPURST])    state_next = ST_RESET;
        else if (ev[EV_RUN])  state_next = ST_RUN;
        else if (ev[EV_STEP]) state_next = ST_STEP;
      end
      ST_RUN: begin
        if (ev[EV_CPURST])              state_next = ST_RESET;
        else if (ev[EV_RUN] || bp_hit)  state_next = ST_HALT;
      end
      ST_STEP: begin
        state_next = ev[EV_CPURST] ? ST_RESET : ST_HALT;
      end
      ST_RESET: begin
        if (!ev[EV_CPURST] && rcnt == RCNT_LAST) state_next = ST_HALT;
      end
      default: state_next = ST_RESET;
    endcase
  end

  // rcnt sits at zero outside RESET so every entry yields a full reset pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt <= '0;
    end else if (state != ST_RESET || ev[EV_CPURST]) begin
      rcnt <= '0;
    end else if (rcnt != RCNT_LAST) begin
      rcnt <= rcnt + RCNT_W'(1);
    end
  end

`ifdef BREAKPOINT_EN
  logic bp_armed;

  // Disarmed for the first RUN cycle after HALT so a resume executes the bp instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_armed <= 1'b1;
    end else begin
      bp_armed <= ~(state == ST_HALT && state_next == ST_RUN);
    end
  end

  assign bp_hit = (state == ST_RUN) & bp_valid & (pc == bp_addr) & bp_armed;
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr, bp_valid};
  assign bp_hit    = 1'b0;
`endif

  assign cpu_rst = (state == ST_RESET);
  assign cpu_en  = (state == ST_STEP) | ((state == ST_RUN) & ~bp_hit);
  assign state_o = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
    end else if (state == ST_RESET) begin
      step_cnt <= '0;
    end else if (cpu_en) begin
      step_cnt <= step_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with DB_CYCLES=8, RST_CYCLES=4; a tiny CPU model advances pc.
module tb_cpu_run_ctrl;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        btn_run    = 1'b0;
  logic        btn_step   = 1'b0;
  logic        btn_cpurst = 1'b0;
  logic [31:0] pc         = 32'd0;
  logic [31:0] bp_addr    = 32'd0;
  logic        bp_valid   = 1'b0;
  logic        cpu_en;
  logic        cpu_rst;
  logic [1:0]  state_o;
  logic [15:0] step_cnt;

  int total    = 0;
  int bad      = 0;
  int en_count = 0;
  int n;

  // Button press to visible state change: 2 sync edges + 8 stable edges + 1 FSM edge.
  localparam int LAT = 11;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .DB_CYCLES (8),
    .CNT_W     (4),
    .RST_CYCLES(4),
    .PC_W      (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_run   (btn_run),
    .btn_step  (btn_step),
    .btn_cpurst(btn_cpurst),
    .pc        (pc),
    .bp_addr   (bp_addr),
    .bp_valid  (bp_valid),
    .cpu_en    (cpu_en),
    .cpu_rst   (cpu_rst),
    .state_o   (state_o),
    .step_cnt  (step_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the CPU model samples cpu_en/cpu_rst just before the edge.
  task automatic cyc();
    logic en_prev;
    logic rst_prev;
    en_prev  = cpu_en;
    rst_prev = cpu_rst;
    @(posedge clk);
    #1;
    if (rst_prev) begin
      pc = 32'd0;
    end else if (en_prev) begin
      pc = pc + 32'd4;
      en_count++;
    end
    #1;
  endtask

  task automatic cycles(input int k);
    repeat (k) cyc();
  endtask

  task automatic wait_state(input logic [1:0] target, input int budget, output int cnt);
    cnt = 0;
    while (cnt < budget && state_o !== target) begin
      cyc();
      cnt++;
    end
  endtask

  initial begin
    // reset behaviour
    cycles(3);
    chk("rst_state", state_o, 2'd3);
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_cpu_en", cpu_en, 1'b0);
    chk("rst_step_cnt", step_cnt, 16'd0);
    rst = 1'b0;
    #1;
    chk("rel_cpu_rst0", cpu_rst, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rel_cpu_rst", cpu_rst, 1'b1);
    end
    cyc();
    chk("rel_halt", state_o, 2'd0);
    chk("rel_cpu_en", cpu_en, 1'b0);
    chk("rel_step_cnt", step_cnt, 16'd0);

    // bouncing step button, then a clean hold
    en_count = 0;
    for (int i = 0; i < 6; i++) begin
      btn_step = ~btn_step;
      cycles(3);
    end
    chk("bounce_no_step", en_count, 0);
    btn_step = 1'b1;
    wait_state(2'd2, 30, n);
    chk("step_latency", n, LAT);
    chk("step_cpu_en", cpu_en, 1'b1);
    cyc();
    chk("step_back_halt", state_o, 2'd0);
    chk("step_en_off", cpu_en, 1'b0);
    btn_step = 1'b0;
    cycles(20);
    chk("step_en_count", en_count, 1);
    chk("step_step_cnt", step_cnt, 16'd1);

    // run for 100 cycles, second press halts
    en_count = 0;
    btn_run = 1'b1;
    wait_state(2'd1, 30, n);
    chk("run_latency", n, LAT);
    btn_run = 1'b0;
    cycles(100);
    chk("run_still", state_o, 2'd1);
    btn_run = 1'b1;
    wait_state(2'd0, 30, n);
    chk("halt_latency", n, LAT);
    chk("run_en_count", en_count, 111);
    chk("run_step_cnt", step_cnt, 16'd112);
    btn_run = 1'b0;
    cycles(15);
    chk("run_release_halt", state_o, 2'd0);

    // run and step together from HALT: run wins
    btn_run  = 1'b1;
    btn_step = 1'b1;
    wait_state(2'd1, 30, n);
    chk("runstep_latency", n, LAT);
    chk("runstep_en", cpu_en, 1'b1);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    cycles(15);
    chk("runstep_still_run", state_o, 2'd1);

    // cpurst and run together while RUN: reset wins, then HALT
    btn_run    = 1'b1;
    btn_cpurst = 1'b1;
    wait_state(2'd3, 30, n);
    chk("cpurst_latency", n, LAT);
    chk("cpurst_cpu_rst", cpu_rst, 1'b1);
    chk("cpurst_cpu_en", cpu_en, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("cpurst_hold", cpu_rst, 1'b1);
    end
    chk("cpurst_step_clr", step_cnt, 16'd0);
    cyc();
    chk("cpurst_halt", state_o, 2'd0);
    chk("cpurst_pc", pc, 32'd0);
    btn_run    = 1'b0;
    btn_cpurst = 1'b0;
    cycles(15);
    chk("cpurst_not_run", state_o, 2'd0);

`ifdef BREAKPOINT_EN
    bp_valid = 1'b1;
    bp_addr  = 32'h40;
    btn_run  = 1'b1;
    wait_state(2'd1, 30, n);
    chk("bp_run_latency", n, LAT);
    btn_run = 1'b0;
    cycles(16);
    chk("bp_pc", pc, 32'h40);
    chk("bp_state", state_o, 2'd1);
    chk("bp_en_off", cpu_en, 1'b0);
    cyc();
    chk("bp_halt", state_o, 2'd0);
    chk("bp_pc_hold", pc, 32'h40);
    cycles(15);
    btn_run = 1'b1;
    wait_state(2'd1, 30, n);
    btn_run = 1'b0;
    chk("bp_resume_en", cpu_en, 1'b1);
    cyc();
    chk("bp_past_pc", pc, 32'h44);
    chk("bp_past_state", state_o, 2'd1);
    cycles(15);
    btn_run = 1'b1;
    wait_state(2'd0, 30, n);
    btn_run  = 1'b0;
    bp_valid = 1'b0;
    cycles(15);
`endif

    // run button held through rst release is seen as a press
    btn_run = 1'b1;
    cycles(5);
    rst = 1'b1;
    #1;
    chk("midrst_state", state_o, 2'd3);
    chk("midrst_cpu_en", cpu_en, 1'b0);
    cycles(2);
    rst = 1'b0;
    wait_state(2'd1, 40, n);
    chk("held_press_latency", n, LAT);
    btn_run = 1'b0;
    cycles(15);
    btn_run = 1'b1;
    wait_state(2'd0, 30, n);
    chk("held_halt", state_o, 2'd0);
    btn_run = 1'b0;
    cycles(15);

    // step_cnt wrap while running
    btn_run = 1'b1;
    wait_state(2'd1, 30, n);
    btn_run = 1'b0;
    n = 0;
    while (step_cnt !== 16'hFFFF && n < 70000) begin
      cyc();
      n++;
    end
    chk("wrap_max", step_cnt, 16'hFFFF);
    chk("wrap_state_pre", state_o, 2'd1);
    cyc();
    chk("wrap_zero", step_cnt, 16'd0);
    chk("wrap_state_post", state_o, 2'd1);
    chk("wrap_en", cpu_en, 1'b1);
    btn_run = 1'b1;
    wait_state(2'd0, 30, n);
    chk("wrap_halt_latency", n, LAT);
    chk("wrap_step_cnt", step_cnt, 16'd11);
    btn_run = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
